pipe_stage: RTL and testbench
=============================

# pipe_stage

Parametrised elastic pipeline register, the successor to the fixed IF_ID-style stage registers in the myCPU datapath. It sits between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB) and carries a DATA_W-bit bundle. It uses a valid/ready handshake, a two-entry skid buffer so upstream readiness is registered, synchronous flush that inserts a NOP bubble, and a saturating stall-cycle counter for performance visibility. One instance replaces each hand-written stage register; the bundle contents are chosen by the instantiating top.

## Interface
- DATA_W, 64: width of the stage bundle (e.g. {pc, inst} for IF/ID).
- NOP_VALUE, {DATA_W{1'b0}}: value on out_data when the stage is empty, after reset, or after flush.
- CNT_W, 16: width of stall_cnt.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  discard all held entries at the next edge.
- in_valid  in  1  upstream has a bundle on in_data.
- in_ready  out  1  stage can accept; this is a registered output.
- in_data  in  DATA_W  upstream bundle.
- out_valid  out  1  out_data holds a valid bundle.
- out_ready  in  1  downstream accepts this cycle (deasserted = stall).
- out_data  out  DATA_W  bundle presented downstream.
- occupancy  out  2  number of held entries (0, 1 or 2).
- stall_cnt  out  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0.

## Operation
- Storage: main register (drives out_data) plus skid register. The state follows occupancy:
  - EMPTY: occupancy 0, out_valid 0, in_ready 1.
  - BUSY: occupancy 1, out_valid 1, in_ready 1.
  - FULL: occupancy 2, out_valid 1, in_ready 0.
- accept = in_valid & in_ready; fire = out_valid & out_ready.
- EMPTY: on accept, go to BUSY and load main from in_data. Otherwise hold.
- BUSY:
  - accept & fire: stay BUSY and load main from in_data.
  - accept & !fire: go to FULL and load skid from in_data.
  - !accept & fire: go to EMPTY and set main to NOP_VALUE.
  - Otherwise hold.
- FULL: no accept is possible.
  - fire: go to BUSY, copy main from skid, and set skid to NOP_VALUE.
  - Otherwise hold.
- Ordering: bundles leave in arrival order. Nothing is duplicated or dropped unless flush is asserted.
- flush: has priority over accept and every transition.
  - Next state is EMPTY, and main and skid become NOP_VALUE.
  - An in_data offered that cycle is discarded even if in_ready=1.
  - A fire in the flush cycle completes normally: the downstream consumer legitimately took the current out_data.
- out_data equals NOP_VALUE whenever out_valid=0.
- stall_cnt:
  - Increments by 1 on each edge where out_valid=1 and out_ready=0.
  - Saturates at 2^CNT_W-1, with no wrap.
  - Unaffected by flush; cleared only by rst.

## Timing
- Reset values while rst is high and after release: state EMPTY, out_valid 0, in_ready 1, out_data NOP_VALUE, occupancy 0, stall_cnt 0. Skid holds NOP_VALUE.
- Latency: a bundle accepted at edge N is on out_data with out_valid=1 after edge N (1 cycle) when the stage was EMPTY, or when it was BUSY and fired.
- Throughput: 1 bundle/cycle while out_ready is held high. There is no bubble at steady state.
- in_ready has no combinational path from out_ready. It falls the edge after the skid fills and rises the edge after FULL fires.
- A stall lasting one or more cycles absorbs exactly one extra bundle (in the skid). The upstream sees in_ready=0 from the following cycle.
- rst asserted mid-operation clears all state immediately (asynchronously). Held bundles are lost.
- flush and rst together: rst governs.

## Test plan
- Streaming: reset, then send 0x01..0x08 with in_valid=1 and out_ready=1 constantly.
  - out_data shows 0x01..0x08 on consecutive cycles, starting 1 cycle after the first accept.
  - in_ready stays 1 and occupancy stays 1.
- Stall: with the stage BUSY holding 0xA, send 0xB and drop out_ready for 3 cycles.
  - 0xB is accepted, then occupancy=2 and in_ready=0.
  - stall_cnt=3.
  - Raise out_ready: out_data is 0xA, then 0xB. Then occupancy returns to 1 and in_ready returns to 1.
- Flush: flush in the FULL state (0xA, 0xB) with in_valid=1 and in_data=0xC, out_ready=0.
  - Next cycle: out_valid=0, out_data=NOP_VALUE, occupancy=0, in_ready=1.
  - 0xC never appears.
- Flush with fire: BUSY with 0x5, out_ready=1, flush=1, in_data=0x6 offered.
  - 0x5 is consumed, 0x6 is dropped, and the state becomes EMPTY.
- Saturation: with CNT_W=4, hold out_valid=1 and out_ready=0 for 20 cycles.
  - stall_cnt=15.
  - Asserting flush leaves it at 15; pulsing rst clears it to 0.
- Async reset: assert rst mid-cycle in the FULL state.
  - Outputs take reset values before the next clk edge, with no clk edge required.

Source files
------------

// File: rtl/pipe_stage.sv
// pipe_stage: elastic valid/ready pipeline register with skid buffer, flush-to-NOP and saturating stall counter.
module pipe_stage #(
  parameter int DATA_W = 64,
  parameter logic [DATA_W-1:0] NOP_VALUE = {DATA_W{1'b0}},
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);
  typedef enum logic [1:0] {EMPTY = 2'd0, BUSY = 2'd1, FULL = 2'd2} state_t;
  state_t state, state_nx;
  logic [DATA_W-1:0] main_q, main_nx, skid_q, skid_nx;
  logic ready_q, accept, fire;
  assign out_valid = state != EMPTY;
  assign in_ready  = ready_q;
  assign out_data  = main_q;
  assign occupancy = state;
  assign accept    = in_valid & ready_q;
  assign fire      = out_valid & out_ready;
  always_comb begin
    state_nx = state;
    main_nx  = main_q;
    skid_nx  = skid_q;
    unique case (state)
      EMPTY: if (accept) begin
        state_nx = BUSY;
        main_nx  = in_data;
      end
      BUSY: if (accept && fire) main_nx = in_data;
        else if (accept) begin
          state_nx = FULL;
          skid_nx  = in_data;
        end else if (fire) begin
          state_nx = EMPTY;
          main_nx  = NOP_VALUE;
        end
      FULL: if (fire) begin
        state_nx = BUSY;
        main_nx  = skid_q;
        skid_nx  = NOP_VALUE;
      end
      default: state_nx = EMPTY;
    endcase
    // flush overrides every transition; a same-cycle fire has already been taken downstream
    if (flush) begin
      state_nx = EMPTY;
      main_nx  = NOP_VALUE;
      skid_nx  = NOP_VALUE;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= EMPTY;
      main_q    <= NOP_VALUE;
      skid_q    <= NOP_VALUE;
      ready_q   <= 1'b1;
      stall_cnt <= '0;
    end else begin
      state     <= state_nx;
      main_q    <= main_nx;
      skid_q    <= skid_nx;
      ready_q   <= state_nx != FULL;
      stall_cnt <= (out_valid && !out_ready && stall_cnt != '1) ? stall_cnt + 1'b1 : stall_cnt;
    end
  end
endmodule

// File: tb/tb_pipe_stage.sv
// tb_pipe_stage: directed scenarios plus randomized traffic checked against a queue model of the stage.
module tb_pipe_stage;
  localparam logic [7:0] NOP = 8'hEE;
  logic clk, rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [7:0] in_data, out_data;
  logic [1:0] occupancy;
  logic [3:0] stall_cnt;
  logic run;
  int checks = 0, errs = 0;
  logic [7:0] q[$];
  int mcnt = 0;
  logic [7:0] last_fired = 8'h00;

  pipe_stage #(.DATA_W(8), .NOP_VALUE(NOP), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // model: FIFO of up to two bundles in arrival order
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      mcnt = 0;
    end else begin : upd
      bit acc, fr;
      acc = in_valid && q.size() < 2;
      fr  = q.size() > 0 && out_ready;
      if (q.size() > 0 && !out_ready && mcnt < 15) mcnt++;
      if (fr) last_fired = q.pop_front();
      if (flush) q.delete();
      else if (acc) q.push_back(in_data);
    end
  end

  always @(negedge clk) begin
    if (run) begin
      chk("m_valid", out_valid, q.size() > 0);
      chk("m_data", out_data, q.size() > 0 ? q[0] : NOP);
      chk("m_occ", occupancy, q.size());
      chk("m_ready", in_ready, q.size() < 2);
      chk("m_cnt", stall_cnt, mcnt);
    end
  end

  initial begin
    run = 1'b0; rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_data", out_data, NOP);
    chk("rst_occ", occupancy, 0);
    chk("rst_cnt", stall_cnt, 0);
    rst = 1'b0; run = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = 8'(i); out_ready = 1'b1;
      @(negedge clk);
      chk("stream_data", out_data, i);
      chk("stream_occ", occupancy, 1);
      chk("stream_ready", in_ready, 1);
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("stream_drain", out_valid, 0);
    in_valid = 1'b1; in_data = 8'h0A; out_ready = 1'b0;
    @(negedge clk);
    in_data = 8'h0B;
    @(negedge clk);
    chk("stall_full", occupancy, 2);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("stall_occ", occupancy, 2);
    chk("stall_ready", in_ready, 0);
    chk("stall_cnt", stall_cnt, 3);
    chk("stall_head", out_data, 8'h0A);
    out_ready = 1'b1;
    @(negedge clk);
    chk("stall_second", out_data, 8'h0B);
    chk("stall_occ1", occupancy, 1);
    chk("stall_ready1", in_ready, 1);
    @(negedge clk);
    chk("stall_empty", occupancy, 0);
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h0A;
    @(negedge clk);
    in_data = 8'h0B;
    @(negedge clk);
    flush = 1'b1; in_data = 8'h0C;
    @(negedge clk);
    chk("flush_valid", out_valid, 0);
    chk("flush_data", out_data, NOP);
    chk("flush_occ", occupancy, 0);
    chk("flush_ready", in_ready, 1);
    chk("flush_cnt", stall_cnt, 5);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("flush_no_c", out_valid, 0);
    end
    in_valid = 1'b1; in_data = 8'h05;
    @(negedge clk);
    in_data = 8'h06; flush = 1'b1;
    @(negedge clk);
    chk("ffire_occ", occupancy, 0);
    chk("ffire_consumed", last_fired, 8'h05);
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("ffire_no_6", out_valid, 0);
    in_valid = 1'b1; in_data = 8'h77; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (20) @(negedge clk);
    chk("sat_cnt", stall_cnt, 15);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("sat_flush", stall_cnt, 15);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 chk("sat_rst", stall_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b1; in_data = 8'h0A; out_ready = 1'b0;
    @(negedge clk);
    in_data = 8'h0B;
    @(negedge clk);
    in_valid = 1'b0;
    chk("arst_full", occupancy, 2);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_ready", in_ready, 1);
    chk("arst_data", out_data, NOP);
    chk("arst_occ", occupancy, 0);
    chk("arst_cnt", stall_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (400) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data = 8'($urandom);
      out_ready = $urandom_range(0, 9) < 7;
      flush = $urandom_range(0, 19) == 0;
      @(negedge clk);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errs);
    $finish;
  end
endmodule
